// File: rtl/hack_pkg.sv
// -----------------------------------------------------------------------------
// hack_pkg
// Shared definitions for the Hack 16-bit word datapath blocks.
//   WORD_W      : Hack word width (16)
//   hack_word_t : one Hack word
//   SEL_A/SEL_B : router destination select encodings
// -----------------------------------------------------------------------------
package hack_pkg;

   localparam int WORD_W = 16;

   typedef logic [WORD_W-1:0] hack_word_t;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   // Occupancy counter width able to hold 0..depth inclusive.
   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/hack_fifo16.sv
// -----------------------------------------------------------------------------
// hack_fifo16
// Synchronous FIFO of DEPTH Hack words with registered full/empty flags.
// No bypass: a word pushed into an empty FIFO shows on head_data the cycle
// after the push. Push while full and pop while empty are ignored.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset (clears storage too)
//   push       in   write push_data at the tail
//   push_data  in   word to write
//   pop        in   advance the head
//   head_data  out  word at the head (meaningless while empty)
//   empty      out  occupancy == 0 (registered)
//   full       out  occupancy == DEPTH (registered)
// -----------------------------------------------------------------------------
module hack_fifo16
   import hack_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  hack_word_t push_data,
   input  logic       pop,
   output hack_word_t head_data,
   output logic       empty,
   output logic       full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = occ_width(DEPTH);

   hack_word_t       r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_empty;
   logic             r_full;

   logic             w_do_push;
   logic             w_do_pop;
   logic [CNT_W-1:0] w_count_nxt;

   assign w_do_push = push && !r_full;
   assign w_do_pop  = pop  && !r_empty;

   // Push and pop together leave occupancy unchanged.
   always_comb begin
      w_count_nxt = r_count;
      case ({w_do_push, w_do_pop})
         2'b10:   w_count_nxt = r_count + CNT_W'(1);
         2'b01:   w_count_nxt = r_count - CNT_W'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_empty  <= 1'b1;
         r_full   <= 1'b0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
            // DEPTH is a power of two, so natural overflow wraps the pointer.
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count <= w_count_nxt;
         r_empty <= (w_count_nxt == '0);
         r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      end
   end

   assign head_data = r_mem[r_rd_ptr];
   assign empty     = r_empty;
   assign full      = r_full;

endmodule

// File: rtl/hack_dmux16_router.sv
// -----------------------------------------------------------------------------
// hack_dmux16_router
// 1-to-2 valid/ready router for Hack words: each accepted word goes to
// channel A (in_sel=0) or channel B (in_sel=1), each with its own FIFO so a
// stalled consumer only blocks words destined for its own channel.
// Optional feature macro: HACK_DMUX16_STATS_EN adds a_count/b_count, 16-bit
// wrapping counts of words accepted into each channel.
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   in_data/in_sel           word and destination
//   in_valid/in_ready        input handshake; in_ready = selected FIFO not full
//   a_data/a_valid/a_ready   channel A head word and handshake
//   b_data/b_valid/b_ready   channel B head word and handshake
//   a_count, b_count         accept counters (stats build only)
// -----------------------------------------------------------------------------
module hack_dmux16_router
   import hack_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_sel,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [WORD_W-1:0] a_data,
   output logic              a_valid,
   input  logic              a_ready,
   output logic [WORD_W-1:0] b_data,
   output logic              b_valid,
`ifdef HACK_DMUX16_STATS_EN
   output logic [15:0]       a_count,
   output logic [15:0]       b_count,
`endif
   input  logic              b_ready
);

   logic w_a_full, w_a_empty;
   logic w_b_full, w_b_empty;
   logic w_accept;
   logic w_push_a, w_push_b;
   logic w_pop_a,  w_pop_b;

   // Depends only on in_sel and registered flags: never on the consumers'
   // ready, so a full FIFO with a same-cycle pop still refuses the word.
   assign in_ready = (in_sel == SEL_B) ? !w_b_full : !w_a_full;
   assign w_accept = in_valid && in_ready;
   assign w_push_a = w_accept && (in_sel == SEL_A);
   assign w_push_b = w_accept && (in_sel == SEL_B);

   assign a_valid  = !w_a_empty;
   assign b_valid  = !w_b_empty;
   assign w_pop_a  = a_valid && a_ready;
   assign w_pop_b  = b_valid && b_ready;

   hack_fifo16 #(.DEPTH(DEPTH)) u_fifo_a (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push_a),
      .push_data (in_data),
      .pop       (w_pop_a),
      .head_data (a_data),
      .empty     (w_a_empty),
      .full      (w_a_full)
   );

   hack_fifo16 #(.DEPTH(DEPTH)) u_fifo_b (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push_b),
      .push_data (in_data),
      .pop       (w_pop_b),
      .head_data (b_data),
      .empty     (w_b_empty),
      .full      (w_b_full)
   );

`ifdef HACK_DMUX16_STATS_EN
   logic [15:0] r_a_count;
   logic [15:0] r_b_count;

   // Counts wrap 0xFFFF -> 0x0000 by natural overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_count <= '0;
         r_b_count <= '0;
      end else begin
         if (w_push_a) r_a_count <= r_a_count + 16'd1;
         if (w_push_b) r_b_count <= r_b_count + 16'd1;
      end
   end

   assign a_count = r_a_count;
   assign b_count = r_b_count;
`endif

endmodule

// File: tb/tb_hack_dmux16_router.sv
// -----------------------------------------------------------------------------
// tb_hack_dmux16_router
// Scoreboard bench: per-channel queues hold the words the router should be
// buffering; a negedge monitor compares handshake outputs and head words
// against them. Build with HACK_DMUX16_STATS_EN to cover the counters.
// -----------------------------------------------------------------------------
module tb_hack_dmux16_router;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] in_data;
   logic        in_sel;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a_data, b_data;
   logic        a_valid, b_valid;
   logic        a_ready, b_ready;
`ifdef HACK_DMUX16_STATS_EN
   logic [15:0] a_count, b_count;
`endif

   hack_dmux16_router #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_sel   (in_sel),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a_data   (a_data),
      .a_valid  (a_valid),
      .a_ready  (a_ready),
      .b_data   (b_data),
      .b_valid  (b_valid),
`ifdef HACK_DMUX16_STATS_EN
      .a_count  (a_count),
      .b_count  (b_count),
`endif
      .b_ready  (b_ready)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: words buffered per channel, and accept counts.
   logic [15:0] qa[$];
   logic [15:0] qb[$];
   logic [15:0] m_acnt = 16'd0;
   logic [15:0] m_bcnt = 16'd0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: checks outputs against the model, then applies this cycle's
   // pops and accept so the model matches the state after the next edge.
   always @(negedge clk) begin
      logic exp_rdy;
      if (rst) begin
         qa.delete();
         qb.delete();
         m_acnt = 16'd0;
         m_bcnt = 16'd0;
      end else begin
         exp_rdy = in_sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
         chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
         chk("a_valid", {31'd0, a_valid}, {31'd0, qa.size() != 0});
         chk("b_valid", {31'd0, b_valid}, {31'd0, qb.size() != 0});
         if (qa.size() != 0) chk("a_data", {16'd0, a_data}, {16'd0, qa[0]});
         if (qb.size() != 0) chk("b_data", {16'd0, b_data}, {16'd0, qb[0]});
`ifdef HACK_DMUX16_STATS_EN
         chk("a_count", {16'd0, a_count}, {16'd0, m_acnt});
         chk("b_count", {16'd0, b_count}, {16'd0, m_bcnt});
`endif
         if (a_ready && qa.size() != 0) void'(qa.pop_front());
         if (b_ready && qb.size() != 0) void'(qb.pop_front());
         if (in_valid && exp_rdy) begin
            if (in_sel) begin qb.push_back(in_data); m_bcnt = m_bcnt + 16'd1; end
            else        begin qa.push_back(in_data); m_acnt = m_acnt + 16'd1; end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Hold the presented word until accepted; optionally randomise readies.
   task automatic wait_accept(input bit rnd_rdy);
      bit ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         if (rnd_rdy) begin
            a_ready = 1'($urandom);
            b_ready = 1'($urandom);
         end
      end
      in_valid = 1'b0;
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout: word %h never accepted", in_data);
      end
   endtask

   task automatic send(input logic [15:0] d, input logic s, input bit rnd_rdy);
      in_data  = d;
      in_sel   = s;
      in_valid = 1'b1;
      wait_accept(rnd_rdy);
   endtask

   initial begin
      int t0;
      rst = 1'b1; in_data = '0; in_sel = 1'b0; in_valid = 1'b0;
      a_ready = 1'b0; b_ready = 1'b0;
      repeat (2) step();
      rst = 1'b0;
      // Reset state: both selects must report ready with nothing buffered.
      @(negedge clk);
      chk("rst_in_ready_a", {31'd0, in_ready}, 32'd1);
      chk("rst_a_valid", {31'd0, a_valid}, 32'd0);
      chk("rst_b_valid", {31'd0, b_valid}, 32'd0);
      step();
      in_sel = 1'b1;
      step();

      // Alternating routing with both consumers ready.
      a_ready = 1'b1; b_ready = 1'b1;
      send(16'h1234, 1'b0, 1'b0);
      send(16'h9876, 1'b1, 1'b0);
      repeat (3) step();

      // Backpressure on A; B traffic continues.
      a_ready = 1'b0;
      send(16'hAAAA, 1'b0, 1'b0);
      send(16'h5555, 1'b0, 1'b0);
      send(16'hFFFF, 1'b1, 1'b0);
      in_data = 16'h0F0F; in_sel = 1'b0; in_valid = 1'b1;
      repeat (3) step();
      @(negedge clk);
      chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      a_ready = 1'b1;
      wait_accept(1'b0);
      repeat (4) step();

      // One word held in A, then push+pop every cycle.
      a_ready = 1'b0;
      send(16'hBEEF, 1'b0, 1'b0);
      a_ready = 1'b1;
      t0 = cyc;
      for (int k = 1; k <= 16; k++) send(16'(k), 1'b0, 1'b0);
      chk("stream_cycles", 32'(cyc - t0), 32'd16);
      repeat (3) step();

      // Reset mid-stream with A=2, B=1 buffered.
      a_ready = 1'b0; b_ready = 1'b0;
      send(16'hA001, 1'b0, 1'b0);
      send(16'hA002, 1'b0, 1'b0);
      send(16'hB001, 1'b1, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      in_sel = 1'b0;
      @(negedge clk);
      chk("mid_rst_a_valid", {31'd0, a_valid}, 32'd0);
      chk("mid_rst_b_valid", {31'd0, b_valid}, 32'd0);
      chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      a_ready = 1'b1;
      send(16'hC0DE, 1'b0, 1'b0);
      repeat (3) step();

      // Randomised traffic and consumer stalls.
      for (int n = 0; n < 400; n++) send(16'($urandom), 1'($urandom), 1'b1);
      a_ready = 1'b1; b_ready = 1'b1;
      repeat (6) step();

`ifdef HACK_DMUX16_STATS_EN
      // Counter wrap on B.
      rst = 1'b1;
      step();
      rst = 1'b0;
      b_ready = 1'b1;
      for (int n = 0; n < 65537; n++) send(16'($urandom), 1'b1, 1'b0);
      @(negedge clk);
      chk("wrap_b_count", {16'd0, b_count}, 32'h0000_0001);
      chk("wrap_a_count", {16'd0, a_count}, 32'h0000_0000);
      repeat (3) step();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
